// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one I2C write master between
// NREQ requesters, with NACK retry, per-attempt timeout and per-requester completion.
module i2c_txn_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   cpl,
  output logic              cpl_err,
  output logic              busy,
  output logic              m_en,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_data,
  input  logic              m_done,
  input  logic              m_ack
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_RETRY, S_CPL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             err_nxt;
  logic [PTR_W-1:0] ptr;
  logic [TMR_W-1:0] tmr;
  logic [RTY_W-1:0] rty;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;

  // Search upward from the last winner so it becomes lowest priority next round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The timeout compare looks one count ahead so CPL lands TIMEOUT+1 cycles after m_start.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ARB;
      S_ARB:   state_nxt = win_found ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (m_done) begin
          if (m_ack) begin
            state_nxt = S_CPL;
          end else if (rty < RTY_MAX) begin
            state_nxt = S_RETRY;
          end else begin
            state_nxt = S_CPL;
            err_nxt   = 1'b1;
          end
        end else if (tmr == TMR_LAST) begin
          state_nxt = S_CPL;
          err_nxt   = 1'b1;
        end
      end
      S_RETRY: state_nxt = S_ISSUE;
      S_CPL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= PTR_W'(NREQ - 1);
      tmr     <= '0;
      rty     <= '0;
      gnt     <= '0;
      cpl     <= '0;
      cpl_err <= 1'b0;
      busy    <= 1'b0;
      m_en    <= 1'b0;
      m_start <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
    end else begin
      busy    <= (state_nxt != S_IDLE);
      m_en    <= (state_nxt != S_IDLE);
      m_start <= (state_nxt == S_ISSUE);
      cpl     <= (state_nxt == S_CPL) ? gnt : '0;
      cpl_err <= (state_nxt == S_CPL) && err_nxt;

      if (state == S_ARB && win_found) begin
        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        m_addr <= req_addr[7*win_idx +: 7];
        m_data <= req_data[8*win_idx +: 8];
        ptr    <= win_idx;
        rty    <= '0;
      end
      if (state == S_CPL) gnt <= '0;

      if (state == S_ISSUE) begin
        tmr <= '0;
      end else if (state == S_WAIT) begin
        tmr <= tmr + 1'b1;
      end

      if (state == S_WAIT && m_done && !m_ack && rty < RTY_MAX) rty <= rty + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter: the bench plays requesters and master, and a
// transaction-level model predicts winner, launch cycles, completion cycle and error flag.
module tb_i2c_txn_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 15;
  localparam int AW        = 7 * NREQ;
  localparam int DW        = 8 * NREQ;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_data = '0;
  logic [NREQ-1:0] gnt, cpl;
  logic            cpl_err, busy, m_en, m_start;
  logic [6:0]      m_addr;
  logic [7:0]      m_data;
  logic            m_done = 1'b0;
  logic            m_ack = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int last_gnt;
  int obs_gnt;
  int start_cnt = 0;
  int cpl_cnt = 0;
  logic [NREQ-1:0] pend_raise = '0;

  i2c_txn_arbiter #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .cpl(cpl), .cpl_err(cpl_err), .busy(busy), .m_en(m_en),
    .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_done(m_done), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_start) start_cnt++;
    if (|cpl) cpl_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first set request searching upward from the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // 0 = ACK, 1 = NACK, 2 = no m_done (timeout)
  function automatic int pick_kind(input int mode, input int att);
    int r;
    case (mode)
      1: return 0;
      2: return 1;
      3: return (att == 0) ? 1 : 0;
      4: return 2;
      default: begin
        r = $urandom_range(0, 9);
        return (r < 5) ? 0 : (r < 9) ? 1 : 2;
      end
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_men"}, m_en, 1'b0);
    check({tag, "_gnt"}, gnt, '0);
    check({tag, "_cpl"}, cpl, '0);
    check({tag, "_start"}, m_start, 1'b0);
  endtask

  task automatic apply_reset();
    req = '0;
    m_done = 1'b0;
    pend_raise = '0;
    reset_n = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    check("rst_err", cpl_err, 1'b0);
    check("rst_addr", m_addr, 7'h0);
    check("rst_data", m_data, 8'h0);
    reset_n = 1'b1;
    last_gnt = NREQ - 1;
  endtask

  // Entered in an IDLE cycle T with req already driven; returns in the IDLE cycle after CPL.
  task automatic do_txn(input int mode, input int fix_d, input logic [NREQ-1:0] wait_raise);
    int w, kind, d;
    bit fin;
    logic [NREQ-1:0] eg, nb;
    logic [6:0] ea;
    logic [7:0] ed;
    tick();
    check("arb_busy", busy, 1'b1);
    check("arb_men", m_en, 1'b1);
    check("arb_gnt", gnt, '0);
    check("arb_start", m_start, 1'b0);
    req = req | pend_raise;
    pend_raise = '0;
    if (mode == 0 && $urandom_range(0, 15) == 0) req = '0;
    w = rr_pick(req, last_gnt);
    tick();
    if (w < 0) begin
      check("arbempty_busy", busy, 1'b0);
      check("arbempty_gnt", gnt, '0);
      check("arbempty_start", m_start, 1'b0);
      return;
    end
    eg = '0;
    eg[w] = 1'b1;
    ea = req_addr[w*7 +: 7];
    ed = req_data[w*8 +: 8];
    last_gnt = w;
    obs_gnt = idx_of(gnt);
    check("issue_gnt", gnt, eg);
    check("issue_start", m_start, 1'b1);
    check("issue_addr", m_addr, ea);
    check("issue_data", m_data, ed);
    fin = 1'b0;
    for (int att = 0; att <= MAX_RETRY && !fin; att++) begin
      kind = pick_kind(mode, att);
      if (kind == 2) d = TIMEOUT + 1;
      else if (fix_d > 0) d = fix_d;
      else d = ($urandom_range(0, 3) == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT);
      for (int k = 1; k < d; k++) begin
        tick();
        if (k == 1) req = req | wait_raise;
        if (mode == 0) begin
          if ($urandom_range(0, 7) == 0) req[w] = 1'b0;
          if ($urandom_range(0, 7) == 0) begin
            nb = NREQ'($urandom);
            req = req | nb;
          end
          req_addr = AW'($urandom);
          req_data = DW'($urandom);
        end
        m_ack = 1'($urandom_range(0, 1));
        check("wait_busy", busy, 1'b1);
        check("wait_cpl", cpl, '0);
        check("wait_start", m_start, 1'b0);
        check("wait_gnt", gnt, eg);
        check("wait_addrdata", {m_data, m_addr}, {ed, ea});
      end
      if (kind == 2) begin
        tick();
        check("tmo_cpl", cpl, eg);
        check("tmo_err", cpl_err, 1'b1);
        fin = 1'b1;
      end else begin
        tick();
        m_done = 1'b1;
        m_ack = (kind == 0);
        check("done_busy", busy, 1'b1);
        check("done_cpl", cpl, '0);
        tick();
        m_done = 1'b0;
        m_ack = 1'($urandom_range(0, 1));
        if (kind == 0) begin
          check("ack_cpl", cpl, eg);
          check("ack_err", cpl_err, 1'b0);
          fin = 1'b1;
        end else if (att < MAX_RETRY) begin
          check("retry_cpl", cpl, '0);
          check("retry_start", m_start, 1'b0);
          check("retry_busy", busy, 1'b1);
          tick();
          check("reissue_start", m_start, 1'b1);
          check("reissue_gnt", gnt, eg);
          check("reissue_addrdata", {m_data, m_addr}, {ed, ea});
        end else begin
          check("nack_cpl", cpl, eg);
          check("nack_err", cpl_err, 1'b1);
          fin = 1'b1;
        end
      end
    end
    tick();
    chk_idle("post");
    req[w] = 1'b0;
  endtask

  int fair_exp[6] = '{0, 1, 2, 3, 0, 1};
  int s0, c0, gap;
  logic [NREQ-1:0] nb;

  initial begin
    req_addr = AW'($urandom);
    req_data = DW'($urandom);
    apply_reset();

    // single request
    req = 4'b0010;
    req_addr[13:7] = 7'h50;
    req_data[15:8] = 8'hA5;
    s0 = start_cnt;
    c0 = cpl_cnt;
    do_txn(1, 10, '0);
    check("single_starts", start_cnt - s0, 1);
    check("single_cpls", cpl_cnt - c0, 1);

    // fairness from reset with everyone requesting
    apply_reset();
    req = '1;
    for (int i = 0; i < 6; i++) begin
      do_txn(1, 0, '0);
      check("fair_order", obs_gnt, fair_exp[i]);
      pend_raise = '0;
      pend_raise[last_gnt] = 1'b1;
    end

    // 0 and 2 requesting while 3 holds the grant
    apply_reset();
    req = 4'b1000;
    do_txn(1, 0, 4'b0101);
    check("wrap_g3", obs_gnt, 3);
    do_txn(1, 0, '0);
    check("wrap_g0", obs_gnt, 0);
    do_txn(1, 0, '0);
    check("wrap_g2", obs_gnt, 2);

    // NACK exhaustion
    apply_reset();
    req = 4'b0100;
    s0 = start_cnt;
    c0 = cpl_cnt;
    do_txn(2, 0, '0);
    check("nackx_starts", start_cnt - s0, MAX_RETRY + 1);
    check("nackx_cpls", cpl_cnt - c0, 1);

    // recovery after one NACK
    apply_reset();
    req = 4'b0001;
    s0 = start_cnt;
    do_txn(3, 0, '0);
    check("recov_starts", start_cnt - s0, 2);

    // timeout, then a late m_done that must be ignored
    apply_reset();
    req = 4'b0001;
    c0 = cpl_cnt;
    do_txn(4, 0, '0);
    tick();
    tick();
    tick();
    m_done = 1'b1;
    m_ack = 1'b1;
    tick();
    m_done = 1'b0;
    chk_idle("late_done");
    tick();
    chk_idle("late_done2");
    check("tmo_cpls", cpl_cnt - c0, 1);

    // reset in the middle of WAIT
    apply_reset();
    req = 4'b1000;
    tick();
    tick();
    check("rw_gnt", gnt, 4'b1000);
    tick();
    tick();
    tick();
    c0 = cpl_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("rw_busy", busy, 1'b0);
    check("rw_men", m_en, 1'b0);
    check("rw_gnt0", gnt, '0);
    check("rw_cpl", cpl, '0);
    check("rw_start", m_start, 1'b0);
    check("rw_addrdata", {m_data, m_addr}, 15'h0);
    tick();
    check("rw_hold", busy, 1'b0);
    reset_n = 1'b1;
    last_gnt = NREQ - 1;
    do_txn(1, 0, '0);
    check("rw_regnt", obs_gnt, 3);
    check("rw_cpls", cpl_cnt - c0, 1);

    // randomized traffic
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      if (req == '0) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          m_done = 1'($urandom_range(0, 1));
          m_ack = 1'($urandom_range(0, 1));
          tick();
          m_done = 1'b0;
          chk_idle("gap");
        end
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      end else if ($urandom_range(0, 1) == 1) begin
        nb = NREQ'($urandom);
        nb[last_gnt] = 1'b0;
        req = req | nb;
      end
      req_addr = AW'($urandom);
      req_data = DW'($urandom);
      do_txn(0, 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
